ras_verify: RTL
===============

Name: ras_verify

Overview:
Execute-side checker for the return-address stack's predictions. Fetch sends each predicted return address (taken when the RAS pops) into an in-order pending queue. When execute resolves the real return target, the block compares it against the oldest pending prediction. On a mismatch it issues a registered redirect and squashes all younger pending predictions. It also keeps saturating hit/miss statistics and sticky error flags for debug readout.

Parameters:
PCW, 14, instruction-address width (matches fetch PC/ra width)
DEPTH_LOG, 3, log2 of pending-queue depth (8 entries)
CNTW, 16, width of the hit and miss statistic counters

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
pred_valid  in  1  fetch used a RAS prediction this cycle
pred_ra  in  PCW  predicted return address
res_valid  in  1  execute resolved a return instruction this cycle (oldest pending first)
res_target  in  PCW  actual return target
flush  in  1  pipeline flush from another source; drops all pending predictions
mispredict  out  1  one-cycle redirect pulse
redirect_pc  out  PCW  correct target; valid while mispredict=1
full  out  1  queue full; fetch must stall prediction use
empty  out  1  queue empty
count  out  DEPTH_LOG+1  number of pending entries (0..2**DEPTH_LOG)
hit_cnt  out  CNTW  saturating count of correct predictions
miss_cnt  out  CNTW  saturating count of mispredicts, underflows included
err_overflow  out  1  sticky: pred_valid arrived while full
err_underflow  out  1  sticky: res_valid arrived while empty

Behaviour:
- Storage: circular buffer of 2**DEPTH_LOG entries with DEPTH_LOG-bit rd/wr pointers that wrap modulo depth; count is a separate register. full = (count==depth); empty = (count==0). Both are combinational from count.
- Reset: pointers, count, mispredict, redirect_pc, hit_cnt, miss_cnt and both err flags are 0. Buffer contents are don't-care. Reset mid-operation discards everything in flight.
- Priority in each cycle: rst > flush > resolve/enqueue.
- flush=1: pointers and count go to 0 next cycle; res_valid and pred_valid are ignored that cycle; mispredict next cycle is 0; counters are unchanged.
- Enqueue: pred_valid=1 and not full writes pred_ra at wr_ptr, then wr_ptr+1 and count+1.
- pred_valid=1 and full: the prediction is dropped, err_overflow is set, and there is no other state change from it.
- Resolve with hit: res_valid=1, not empty, and head==res_target. Pop the head (rd_ptr+1, count-1) and hit_cnt+1. mispredict stays 0.
- Resolve with miss: head!=res_target. Next cycle mispredict=1 and redirect_pc=res_target. The whole queue is cleared (count=0, rd_ptr=wr_ptr), because all younger predictions are wrong-path. miss_cnt+1.
- Resolve when empty: err_underflow set, and the cycle is treated as a miss (mispredict pulse, redirect_pc=res_target, miss_cnt+1).
- Simultaneous pred_valid and res_valid:
  - on a hit, enqueue and pop both happen; count is unchanged. When full, the enqueue is still rejected, because full is evaluated on the current count (conservative).
  - on a miss or underflow, the same-cycle prediction is also squashed and not written; count becomes 0.
- Latency: mispredict and redirect_pc are registered, 1 cycle after the resolving res_valid. count/full/empty reflect updates 1 cycle after the event. Hit compare uses the head read combinationally in the resolve cycle.
- mispredict is a single-cycle pulse; back-to-back misses on consecutive cycles give consecutive pulses. redirect_pc holds its last value when mispredict=0.
- Counters saturate at 2**CNTW-1 and never wrap.
- Err flags clear only on rst.

Test Plan:
- Enqueue then match: pred 0x0100, 0x0200, then res 0x0200 and 0x0100 in FIFO order (head is 0x0100) → the res order mismatches on the first. Therefore drive res 0x0100 then 0x0200 → hit_cnt=2, mispredict never 1, empty=1 afterwards.
- Miss squash: pred 0x0010, 0x0020, 0x0030; res 0x0011 → next cycle mispredict=1, redirect_pc=0x0011, count=0, miss_cnt=1; a following res gives err_underflow=1 and a second pulse.
- Full/overflow with DEPTH_LOG=3: 8 preds → full=1, count=8; 9th pred (0x3FFF) → err_overflow=1, count stays 8; draining 8 hits returns the original order and wraps the pointers.
- Simultaneous: count=3 with head 0x0040; pred 0x0050 plus res 0x0040 in the same cycle → count stays 3 and hit_cnt+1. Repeat with res 0x0041 → count=0 and 0x0050 is not stored.
- Flush priority: count=4; flush together with res_valid mismatching → count=0, no mispredict, miss_cnt unchanged.
- Reset mid-operation: count=5 with a mispredict pending; rst for one cycle → all outputs 0, empty=1, and subsequent enqueue/hit works normally.
- Saturation with CNTW=4: 20 consecutive misses → miss_cnt=15 held.

Source files
------------

// File: rtl/ras_verify.sv
// Execute-side checker for RAS return-address predictions: in-order pending queue,
// compare-on-resolve, registered redirect with younger squash, saturating stats, sticky errors.
module ras_verify #(
  parameter int PCW       = 14,
  parameter int DEPTH_LOG = 3,
  parameter int CNTW      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pred_valid,
  input  logic [PCW-1:0]       pred_ra,
  input  logic                 res_valid,
  input  logic [PCW-1:0]       res_target,
  input  logic                 flush,
  output logic                 mispredict,
  output logic [PCW-1:0]       redirect_pc,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH_LOG:0]   count,
  output logic [CNTW-1:0]      hit_cnt,
  output logic [CNTW-1:0]      miss_cnt,
  output logic                 err_overflow,
  output logic                 err_underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int CW    = DEPTH_LOG + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [PCW-1:0]       mem_q [DEPTH];
  logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 mispredict_q, mispredict_d;
  logic [PCW-1:0]       redirect_pc_q, redirect_pc_d;
  logic [CNTW-1:0]      hit_cnt_q, hit_cnt_d;
  logic [CNTW-1:0]      miss_cnt_q, miss_cnt_d;
  logic                 err_ovf_q, err_ovf_d;
  logic                 err_unf_q, err_unf_d;

  logic           full_w, empty_w;
  logic [PCW-1:0] head;
  logic           res_hit, res_miss, do_enq;

  assign full_w  = (count_q == DEPTH_CNT);
  assign empty_w = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    mispredict_d  = 1'b0;
    redirect_pc_d = redirect_pc_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    err_ovf_d     = err_ovf_q;
    err_unf_d     = err_unf_q;
    res_hit       = 1'b0;
    res_miss      = 1'b0;
    do_enq        = 1'b0;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      res_hit  = res_valid && !empty_w && (head == res_target);
      res_miss = res_valid && !res_hit;
      // A miss squashes everything younger, including a same-cycle prediction.
      do_enq   = pred_valid && !full_w && !res_miss;

      if (pred_valid && full_w) err_ovf_d = 1'b1;

      if (res_miss) begin
        mispredict_d  = 1'b1;
        redirect_pc_d = res_target;
        rd_ptr_d      = wr_ptr_q;
        count_d       = '0;
        if (empty_w) err_unf_d = 1'b1;
        if (miss_cnt_q != {CNTW{1'b1}}) miss_cnt_d = miss_cnt_q + CNTW'(1);
      end else begin
        if (res_hit) begin
          rd_ptr_d = rd_ptr_q + DEPTH_LOG'(1);
          if (hit_cnt_q != {CNTW{1'b1}}) hit_cnt_d = hit_cnt_q + CNTW'(1);
        end
        if (do_enq) wr_ptr_d = wr_ptr_q + DEPTH_LOG'(1);
        count_d = count_q + CW'(do_enq) - CW'(res_hit);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      err_ovf_q     <= 1'b0;
      err_unf_q     <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      err_ovf_q     <= err_ovf_d;
      err_unf_q     <= err_unf_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (!rst && do_enq) mem_q[wr_ptr_q] <= pred_ra;
  end

  assign mispredict    = mispredict_q;
  assign redirect_pc   = redirect_pc_q;
  assign full          = full_w;
  assign empty         = empty_w;
  assign count         = count_q;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;

endmodule
